// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and helpers for the registered N-way mux
package mux_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int MAX_N         = 16;
    localparam int MODE_SEL      = 0;
    localparam int MODE_RR       = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - round-robin grant among N requesters, owns the rotating pointer
module rr_arbiter_n
    import mux_pkg::*;
#(
    parameter int N     = 5,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant_oh,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [PTR_W-1:0] rr_ptr;
    int               idx;

    // Scan starting at rr_ptr; the first requester found wins.
    always_comb begin
        grant_oh    = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!grant_valid && req[idx]) begin
                grant_valid   = 1'b1;
                grant_idx     = idx[PTR_W-1:0];
                grant_oh[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (advance && grant_valid) begin
            rr_ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mux_n_reg.sv
// rtl/mux_n_reg.sv - N-way WIDTH-bit mux with a registered valid/ready output stage
module mux_n_reg
    import mux_pkg::*;
#(
    parameter int  WIDTH   = DEFAULT_WIDTH,
    parameter int  N       = 5,
    parameter int  RR_MODE = MODE_SEL,
    localparam int SEL_W   = (clog2(N) > 1) ? clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SEL_W-1:0]   selector,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_sel,
    output logic               sel_err
);

    localparam logic [SEL_W:0] N_L = (SEL_W + 1)'(N);

    logic             sel_oor;
    logic [SEL_W-1:0] chosen;
    logic [SEL_W-1:0] src;
    logic [N-1:0]     ready_vec;
    logic [N-1:0]     grant_oh;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_valid;
    logic             load_ok;
    logic             take;

    assign sel_oor = {1'b0, selector} >= N_L;
    assign chosen  = sel_oor ? '0 : selector;
    assign load_ok = !out_valid || out_ready;

    generate
        if (RR_MODE == MODE_RR) begin : g_rr
            rr_arbiter_n #(
                .N     (N),
                .PTR_W (SEL_W)
            ) u_arb (
                .clk         (clk),
                .reset       (reset),
                .req         (in_valid),
                .advance     (take),
                .grant_oh    (grant_oh),
                .grant_idx   (grant_idx),
                .grant_valid (grant_valid)
            );
        end else begin : g_sel
            assign grant_oh    = '0;
            assign grant_idx   = '0;
            assign grant_valid = 1'b0;
        end
    endgenerate

    always_comb begin
        if (RR_MODE == MODE_RR) begin
            src       = grant_idx;
            ready_vec = grant_valid ? grant_oh : '0;
        end else begin
            src       = chosen;
            ready_vec = N'(1) << chosen;
        end
    end

    // Gating with reset keeps every channel blocked while reset is held.
    assign in_ready = (reset && load_ok) ? ready_vec : '0;
    assign take     = |(in_valid & in_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sel   <= '0;
            sel_err   <= 1'b0;
        end else begin
            if (take) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(src)*WIDTH +: WIDTH];
                out_sel   <= src;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            sel_err <= (RR_MODE == MODE_SEL) && sel_oor;
        end
    end

endmodule

// File: tb/tb_mux_n_reg.sv
// tb/tb_mux_n_reg.sv - randomized and directed check of mux_n_reg in both modes against a reference model
module tb_mux_n_reg;

    localparam int W = 32;
    localparam int N = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [2:0]     s_selector, r_selector;
    logic [N*W-1:0] s_in_data, r_in_data;
    logic [N-1:0]   s_in_valid, r_in_valid, s_in_ready, r_in_ready;
    logic [W-1:0]   s_out_data, r_out_data;
    logic           s_out_valid, r_out_valid, s_out_ready, r_out_ready;
    logic [2:0]     s_out_sel, r_out_sel;
    logic           s_sel_err, r_sel_err;

    mux_n_reg #(.WIDTH(W), .N(N), .RR_MODE(0)) dut_sel (
        .clk(clk), .reset(reset), .selector(s_selector), .in_data(s_in_data),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .out_data(s_out_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sel(s_out_sel),
        .sel_err(s_sel_err)
    );

    mux_n_reg #(.WIDTH(W), .N(N), .RR_MODE(1)) dut_rr (
        .clk(clk), .reset(reset), .selector(r_selector), .in_data(r_in_data),
        .in_valid(r_in_valid), .in_ready(r_in_ready), .out_data(r_out_data),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_sel(r_out_sel),
        .sel_err(r_sel_err)
    );

    int n_vec = 0;
    int n_err = 0;

    logic        m_sv, m_se, m_rv;
    logic [31:0] m_sd, m_rd;
    int          m_ss, m_rs, m_rptr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [N*W-1:0] bus, input int ch);
        return bus[ch*W +: W];
    endfunction

    task automatic model_reset();
        m_sv = 0; m_sd = 0; m_ss = 0; m_se = 0;
        m_rv = 0; m_rd = 0; m_rs = 0; m_rptr = 0;
    endtask

    task automatic check_outputs();
        check("sel_out_valid", 32'(s_out_valid), 32'(m_sv));
        check("sel_out_data",  s_out_data,       m_sd);
        check("sel_out_sel",   32'(s_out_sel),   m_ss);
        check("sel_err",       32'(s_sel_err),   32'(m_se));
        check("rr_out_valid",  32'(r_out_valid), 32'(m_rv));
        check("rr_out_data",   r_out_data,       m_rd);
        check("rr_out_sel",    32'(r_out_sel),   m_rs);
        check("rr_sel_err",    32'(r_sel_err),   0);
    endtask

    // Inputs are set just after a rising edge; this checks readiness, clocks once, then checks outputs.
    task automatic cycle();
        logic [N-1:0] er_s, er_r;
        int ch, g, idx;
        #1;
        ch = (int'(s_selector) < N) ? int'(s_selector) : 0;
        er_s = (!m_sv || s_out_ready) ? (N'(1) << ch) : '0;
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_rptr + k) % N;
            if (g < 0 && r_in_valid[idx]) g = idx;
        end
        er_r = (g >= 0 && (!m_rv || r_out_ready)) ? (N'(1) << g) : '0;
        check("sel_in_ready", 32'(s_in_ready), 32'(er_s));
        check("rr_in_ready",  32'(r_in_ready), 32'(er_r));
        @(posedge clk);
        if (er_s[ch] && s_in_valid[ch]) begin
            m_sv = 1; m_sd = word_of(s_in_data, ch); m_ss = ch;
        end else if (s_out_ready) begin
            m_sv = 0;
        end
        m_se = int'(s_selector) >= N;
        if (g >= 0 && er_r[g]) begin
            m_rv = 1; m_rd = word_of(r_in_data, g); m_rs = g; m_rptr = (g + 1) % N;
        end else if (r_out_ready) begin
            m_rv = 0;
        end
        #1;
        check_outputs();
    endtask

    function automatic logic [N*W-1:0] rand_bus();
        logic [N*W-1:0] b;
        for (int i = 0; i < N; i++) b[i*W +: W] = $urandom;
        return b;
    endfunction

    initial begin
        reset = 1'b0;
        s_selector = 0; s_in_data = rand_bus(); s_in_valid = '1; s_out_ready = 1;
        r_selector = 0; r_in_data = rand_bus(); r_in_valid = '1; r_out_ready = 1;
        model_reset();
        #2;
        check_outputs();
        check("sel_in_ready_rst", 32'(s_in_ready), 0);
        check("rr_in_ready_rst",  32'(r_in_ready), 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // Selector pass, backpressure with selector change, out-of-range, recovery.
        s_selector = 3; s_in_valid = 5'b01000; s_in_data[3*W +: W] = 32'hDEADBEEF; s_out_ready = 1;
        r_in_valid = 5'b11111; r_out_ready = 1; r_selector = 3'd7;
        cycle();
        check("sel_pass_data", s_out_data, 32'hDEADBEEF);
        s_selector = 1; s_in_valid = 5'b00010; s_in_data[1*W +: W] = 32'h11112222; s_out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            r_in_data = rand_bus();
            cycle();
        end
        check("sel_hold_data", s_out_data, 32'hDEADBEEF);
        s_out_ready = 1;
        cycle();
        check("sel_no_bubble", 32'(s_out_valid), 1);
        s_selector = 7; s_in_valid = 5'b00001; s_in_data[0 +: W] = 32'h1;
        cycle();
        check("sel_oor_err", 32'(s_sel_err), 1);
        s_selector = 2; s_in_valid = 5'b00100;
        cycle();
        check("rr_seq_wrap", 32'(r_out_sel), 1);

        // Round-robin with a sparse request pattern, then idle drain on both.
        r_in_valid = 5'b00101;
        for (int i = 0; i < 3; i++) begin
            r_in_data = rand_bus();
            cycle();
        end
        check("rr_sparse_last", 32'(r_out_sel), 2);
        s_in_valid = '0; r_in_valid = '0; s_out_ready = 1; r_out_ready = 1;
        cycle();
        cycle();

        for (int i = 0; i < 400; i++) begin
            s_selector  = 3'($urandom_range(0, 7));
            r_selector  = 3'($urandom_range(0, 7));
            s_in_data   = rand_bus();
            r_in_data   = rand_bus();
            s_in_valid  = N'($urandom);
            r_in_valid  = N'($urandom);
            s_out_ready = ($urandom_range(0, 3) != 0);
            r_out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Mid-transfer asynchronous reset with words held on both outputs.
        s_selector = 4; s_in_valid = '1; r_in_valid = '1; s_out_ready = 0; r_out_ready = 0;
        cycle();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("sel_in_ready_mid_rst", 32'(s_in_ready), 0);
        check("rr_in_ready_mid_rst",  32'(r_in_ready), 0);
        #2;
        reset = 1'b1;
        s_out_ready = 1; r_out_ready = 1;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
